// File: rtl/partial_tile_collector_if.sv
// Row stream from the MAC array into the partial tile collector.
// The master drives one tile row per beat; the slave signals acceptance with row_ready.
interface partial_tile_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 64
);
  logic                             row_valid;
  logic                             row_ready;
  logic [DATA_WIDTH*BLOCK_SIZE-1:0] row_data;

  modport master (output row_valid, output row_data, input row_ready);
  modport slave  (input row_valid, input row_data, output row_ready);
endinterface

// File: rtl/partial_tile_collector.sv
// Collects one BLOCK_SIZE x BLOCK_SIZE partial tile per step and issues one accumulate pulse
// per tile, sequencing all N^3 block steps of the product for the result accumulator.
module partial_tile_collector #(
  parameter int MATRIX_SIZE = 128,
  parameter int BLOCK_SIZE  = 64,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic                                        abort,
  partial_tile_collector_if.slave                     row_if,
  output logic                                        start_new_computation,
  output logic                                        accumulate_result,
  output logic [1:0]                                  c_row_idx,
  output logic [1:0]                                  c_col_idx,
  output logic [DATA_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] partial_result_flat,
  output logic                                        busy,
  output logic                                        done
);

  localparam int unsigned N      = MATRIX_SIZE / BLOCK_SIZE;
  localparam int unsigned ROW_W  = DATA_WIDTH * BLOCK_SIZE;
  localparam int unsigned RC_W   = $clog2(BLOCK_SIZE);
  localparam int unsigned STEP_W = 7;
  localparam logic [STEP_W-1:0] TOTAL_STEPS = STEP_W'(N * N * N);
  localparam logic [RC_W-1:0]   LAST_ROW    = RC_W'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COLLECT,
    S_ISSUE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                          state, state_nxt;
  logic [RC_W-1:0]                 row_cnt;
  logic [STEP_W-1:0]               step, step_inc, entry_step;
  logic [BLOCK_SIZE-1:0][ROW_W-1:0] tile_buf;
  logic                            row_ready_int;
  logic                            row_wr;

  // k varies fastest, so the C-block indices advance only every N steps.
  function automatic logic [1:0] blk_row(input logic [STEP_W-1:0] s);
    int unsigned v;
    v = 32'(s);
    return 2'(v / (N * N));
  endfunction

  function automatic logic [1:0] blk_col(input logic [STEP_W-1:0] s);
    int unsigned v;
    v = 32'(s);
    return 2'((v / N) % N);
  endfunction

  assign step_inc   = step + STEP_W'(1);
  assign entry_step = (state == S_HOLD) ? step_inc : step;
  assign row_wr     = row_ready_int & row_if.row_valid;

  assign row_if.row_ready    = row_ready_int;
  assign busy                = (state != S_IDLE);
  assign partial_result_flat = tile_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt             = state;
    start_new_computation = 1'b0;
    accumulate_result     = 1'b0;
    done                  = 1'b0;
    row_ready_int         = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: begin
        start_new_computation = 1'b1;
        state_nxt = abort ? S_IDLE : S_COLLECT;
      end
      S_COLLECT: begin
        // Ready drops on abort so no row is handshaken in the cycle we leave.
        if (abort) state_nxt = S_IDLE;
        else begin
          row_ready_int = 1'b1;
          if (row_if.row_valid && row_cnt == LAST_ROW) state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        accumulate_result = 1'b1;
        state_nxt = abort ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (abort)                        state_nxt = S_IDLE;
        else if (step_inc == TOTAL_STEPS) state_nxt = S_DONE;
        else                              state_nxt = S_COLLECT;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      step      <= '0;
      c_row_idx <= '0;
      c_col_idx <= '0;
    end else begin
      if (state != S_IDLE && abort) begin
        row_cnt <= '0;
        step    <= '0;
      end else begin
        if (state == S_IDLE && start) step <= '0;
        if (state == S_HOLD)          step <= step_inc;
        if (row_wr) row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RC_W'(1);
      end
      if (state_nxt == S_COLLECT && state != S_COLLECT) begin
        c_row_idx <= blk_row(entry_step);
        c_col_idx <= blk_col(entry_step);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tile_buf          <= '0;
    else if (row_wr) tile_buf[row_cnt] <= row_if.row_data;
  end

endmodule

// File: tb/tb_partial_tile_collector.sv
// Bench for partial_tile_collector: drives tile rows with random data and stalls and
// checks pulses, indices and the collected buffer against a step-arithmetic model.
module tb_partial_tile_collector;

  localparam int W      = 16;
  localparam int B      = 64;
  localparam int MS     = 128;
  localparam int N      = MS / B;
  localparam int ROW_W  = W * B;
  localparam int FLAT_W = ROW_W * B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic snc, acc, busy, done;
  logic [1:0] c_row, c_col;
  logic [FLAT_W-1:0] flat;
  logic [FLAT_W-1:0] exp_flat = '0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int snc_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  partial_tile_collector_if #(.DATA_WIDTH(W), .BLOCK_SIZE(B)) row_if ();

  partial_tile_collector #(.MATRIX_SIZE(MS), .BLOCK_SIZE(B), .DATA_WIDTH(W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .abort                 (abort),
    .row_if                (row_if),
    .start_new_computation (snc),
    .accumulate_result     (acc),
    .c_row_idx             (c_row),
    .c_col_idx             (c_col),
    .partial_result_flat   (flat),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (snc)  snc_cnt  <= snc_cnt + 1;
      if (acc)  acc_cnt  <= acc_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int first_diff();
    for (int i = 0; i < B * B; i++)
      if (flat[i*W +: W] !== exp_flat[i*W +: W]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] elem(input int r, input int j);
    return flat[(r*B + j)*W +: W];
  endfunction

  // Stimulus only: offers rows of step s until nrows are accepted, recording them in the model.
  // mode 0: always valid, 1: valid low every 3rd ready cycle, 2: random stalls.
  task automatic feed_tile(input int s, input int nrows, input int mode, input bit rnd,
                           output int stalls, output int first_ready);
    int r, k, guard;
    logic [ROW_W-1:0] d;
    bit v;
    r = 0; k = 0; guard = 0; stalls = 0; first_ready = -1;
    while (r < nrows) begin
      for (int j = 0; j < B; j++) d[j*W +: W] = rnd ? W'($urandom) : W'(r + j + 100*s + 1);
      v = 1'b1;
      if (row_if.row_ready === 1'b1) begin
        if (first_ready < 0) first_ready = cyc;
        if (mode == 1 && (k % 3) == 2)                v = 1'b0;
        else if (mode == 2 && $urandom_range(3) == 0) v = 1'b0;
        k++;
        if (!v) stalls++;
        else begin
          exp_flat[r*ROW_W +: ROW_W] = d;
          r++;
        end
      end
      row_if.row_valid = v;
      row_if.row_data  = d;
      @(negedge clk);
      guard++;
      if (guard > 4*nrows + 20) begin
        n_cmp++; n_fail++;
        $display("FAIL feed_timeout step %0d: accepted %0d rows, required %0d", s, r, nrows);
        break;
      end
    end
    row_if.row_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy, row_if.row_ready, snc, acc, done, c_row, c_col} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, row_if.row_ready, snc, acc, done, c_row, c_col});
    end
    n_cmp++;
    if (flat !== exp_flat) begin
      n_fail++; $display("FAIL reset_buf: first bad elem %0d", first_diff());
    end
    rst_n = 1'b1;
    // row_valid in IDLE must not write
    for (int i = 0; i < 4; i++) begin
      row_if.row_valid = 1'b1;
      row_if.row_data  = {32{$urandom}};
      @(negedge clk);
    end
    row_if.row_valid = 1'b0;
    n_cmp++;
    if ({busy, row_if.row_ready} !== 2'b00 || flat !== exp_flat) begin
      n_fail++; $display("FAIL idle_valid_ignored: busy/ready %b, first bad elem %0d", {busy, row_if.row_ready}, first_diff());
    end
  endtask

  task automatic test_start_latency();
    int snc0, acc0;
    while (cyc < 10) @(negedge clk);
    #1; snc0 = snc_cnt; acc0 = acc_cnt;
    row_if.row_valid = 1'b1;
    row_if.row_data  = {32{$urandom}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({snc, row_if.row_ready, busy} !== 3'b101) begin
      n_fail++; $display("FAIL latency_init: snc/ready/busy got %b want 101 at cycle %0d", {snc, row_if.row_ready, busy}, cyc);
    end
    row_if.row_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({snc, row_if.row_ready} !== 2'b01 || flat !== exp_flat) begin
      n_fail++; $display("FAIL latency_collect: snc/ready got %b want 01, first bad elem %0d", {snc, row_if.row_ready}, first_diff());
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, row_if.row_ready} !== 2'b00) begin
      n_fail++; $display("FAIL abort_collect: busy/ready got %b want 00", {busy, row_if.row_ready});
    end
    // start and abort together in IDLE: start wins; abort in INIT still shows the pulse
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({snc, busy} !== 2'b11) begin
      n_fail++; $display("FAIL start_beats_abort: snc/busy got %b want 11", {snc, busy});
    end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, snc} !== 2'b00) begin
      n_fail++; $display("FAIL abort_init: busy/snc got %b want 00", {busy, snc});
    end
    #1;
    n_cmp++;
    if (snc_cnt - snc0 !== 2 || acc_cnt - acc0 !== 0) begin
      n_fail++; $display("FAIL latency_counts: snc %0d acc %0d, want 2 and 0", snc_cnt - snc0, acc_cnt - acc0);
    end
  endtask

  task automatic test_backpressure();
    int stalls, fr, acc0, done0;
    #1; acc0 = acc_cnt; done0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed_tile(0, B, 1, 1'b0, stalls, fr);
    n_cmp++;
    if ({acc, c_row, c_col} !== 5'b10000) begin
      n_fail++; $display("FAIL bp_pulse: acc/row/col got %b want 10000", {acc, c_row, c_col});
    end
    n_cmp++;
    if (flat !== exp_flat) begin
      n_fail++; $display("FAIL bp_buf: first bad elem %0d", first_diff());
    end
    n_cmp++;
    if (elem(63, 63) !== 16'd127 || elem(0, 0) !== 16'd1) begin
      n_fail++; $display("FAIL bp_corner: (63,63)=%0d (0,0)=%0d want 127 and 1", elem(63, 63), elem(0, 0));
    end
    n_cmp++;
    if (cyc - fr !== B + stalls) begin
      n_fail++; $display("FAIL bp_delay: got %0d cycles want %0d", cyc - fr, B + stalls);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_issue: busy got %b want 0", busy);
    end
    repeat (80) @(negedge clk);
    #1;
    n_cmp++;
    if (acc_cnt - acc0 !== 1 || done_cnt - done0 !== 0) begin
      n_fail++; $display("FAIL bp_counts: acc %0d done %0d, want 1 and 0", acc_cnt - acc0, done_cnt - done0);
    end
  endtask

  task automatic test_full_run(input bit rnd, input bit poke);
    int stalls, fr, prev, snc0, acc0, done0;
    #1; snc0 = snc_cnt; acc0 = acc_cnt; done0 = done_cnt; prev = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < N*N*N; s++) begin
      feed_tile(s, B, rnd ? 2 : 0, rnd, stalls, fr);
      n_cmp++;
      if (acc !== 1'b1 || c_row !== 2'(s / (N*N)) || c_col !== 2'((s / N) % N)) begin
        n_fail++; $display("FAIL run_pulse step %0d: acc %b row %0d col %0d want 1 %0d %0d",
                           s, acc, c_row, c_col, s / (N*N), (s / N) % N);
      end
      n_cmp++;
      if (flat !== exp_flat) begin
        n_fail++; $display("FAIL run_buf step %0d: first bad elem %0d", s, first_diff());
      end
      if (!rnd) begin
        n_cmp++;
        if (elem(0, 0) !== W'(100*s + 1)) begin
          n_fail++; $display("FAIL run_elem00 step %0d: got %0d want %0d", s, elem(0, 0), 100*s + 1);
        end
        if (s > 0) begin
          n_cmp++;
          if (cyc - prev !== B + 2) begin
            n_fail++; $display("FAIL run_spacing step %0d: got %0d want %0d", s, cyc - prev, B + 2);
          end
        end
      end else begin
        n_cmp++;
        if (cyc - fr !== B + stalls) begin
          n_fail++; $display("FAIL run_delay step %0d: got %0d want %0d", s, cyc - fr, B + stalls);
        end
      end
      prev = cyc;
      if (poke && s == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({acc, row_if.row_ready, busy} !== 3'b001 || flat !== exp_flat) begin
        n_fail++; $display("FAIL run_hold step %0d: acc/ready/busy %b want 001, first bad elem %0d",
                           s, {acc, row_if.row_ready, busy}, first_diff());
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b11) begin
      n_fail++; $display("FAIL run_done: done/busy got %b want 11", {done, busy});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL run_idle: done/busy got %b want 00", {done, busy});
    end
    n_cmp++;
    if (snc_cnt - snc0 !== 1 || acc_cnt - acc0 !== N*N*N || done_cnt - done0 !== 1) begin
      n_fail++; $display("FAIL run_counts: snc %0d acc %0d done %0d want 1 %0d 1",
                         snc_cnt - snc0, acc_cnt - acc0, done_cnt - done0, N*N*N);
    end
  endtask

  task automatic test_abort_hold();
    int stalls, fr, acc0, done0;
    #1; acc0 = acc_cnt; done0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s <= 4; s++) begin
      feed_tile(s, B, 2, 1'b1, stalls, fr);
      n_cmp++;
      if (acc !== 1'b1 || c_row !== 2'(s / (N*N)) || c_col !== 2'((s / N) % N)) begin
        n_fail++; $display("FAIL ah_pulse step %0d: acc %b row %0d col %0d", s, acc, c_row, c_col);
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, acc, row_if.row_ready} !== 3'b000 || c_row !== 2'(4 / (N*N)) || c_col !== 2'((4 / N) % N)) begin
      n_fail++; $display("FAIL abort_hold: busy/acc/ready %b row %0d col %0d", {busy, acc, row_if.row_ready}, c_row, c_col);
    end
    repeat (100) @(negedge clk);
    #1;
    n_cmp++;
    if (acc_cnt - acc0 !== 5 || done_cnt - done0 !== 0) begin
      n_fail++; $display("FAIL ah_counts: acc %0d done %0d want 5 and 0", acc_cnt - acc0, done_cnt - done0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed_tile(0, B, 0, 1'b0, stalls, fr);
    n_cmp++;
    if ({acc, c_row, c_col} !== 5'b10000 || flat !== exp_flat || elem(0, 0) !== 16'd1) begin
      n_fail++; $display("FAIL restart: acc/row/col %b elem00 %0d first bad elem %0d",
                         {acc, c_row, c_col}, elem(0, 0), first_diff());
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stalls, fr, acc0;
    #1; acc0 = acc_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed_tile(0, B, 0, 1'b1, stalls, fr);
    feed_tile(1, B, 0, 1'b1, stalls, fr);
    feed_tile(2, 20, 0, 1'b1, stalls, fr);
    #2;
    rst_n = 1'b0;
    exp_flat = '0;
    #1;
    n_cmp++;
    if ({busy, row_if.row_ready, snc, acc, done, c_row, c_col} !== 9'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0", {busy, row_if.row_ready, snc, acc, done, c_row, c_col});
    end
    n_cmp++;
    if (flat !== exp_flat) begin
      n_fail++; $display("FAIL rst_mid_buf: first bad elem %0d", first_diff());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, row_if.row_ready} !== 2'b00 || acc_cnt - acc0 !== 2) begin
      n_fail++; $display("FAIL rst_mid_idle: busy/ready %b acc %0d want 00 and 2", {busy, row_if.row_ready}, acc_cnt - acc0);
    end
  endtask

  initial begin
    row_if.row_valid = 1'b0;
    row_if.row_data  = '0;
    test_reset();
    test_start_latency();
    test_backpressure();
    test_full_run(1'b0, 1'b0);
    test_full_run(1'b1, 1'b1);
    test_abort_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
